rev_mac_seq: RTL and testbench
==============================

// Module: rev_mac_seq
// PURPOSE
//   Sequential multiply-accumulate stage fed by the reversible fan-out/XOR gate
//   layer: takes a stream of (a,b) operand pairs for one matrix-product element
//   and returns the dot product sum(a_i*b_i).
//   Each product uses a shift-add multiplier (one partial product per cycle).
//   The result leaves on a valid/ready port to the result-matrix writer.
// PARAMETERS
//   WIDTH      4    operand width in bits (unsigned), >=2
//   ACC_WIDTH  12   accumulator/result width; sums wrap modulo 2^ACC_WIDTH
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          operand pair present
//   in_ready   out  1          block can accept a pair (high only in IDLE)
//   in_a       in   WIDTH      multiplicand
//   in_b       in   WIDTH      multiplier
//   in_last    in   1          pair is the final term of the dot product
//   out_valid  out  1          result available
//   out_ready  in   1          downstream accepts result
//   out_data   out  ACC_WIDTH  dot-product result
//   out_ovf    out  1          sticky: a carry out of ACC_WIDTH occurred this dot product
// BEHAVIOUR
//   - Single clock; rst sampled on posedge only. rst has priority over all inputs.
//   - Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0.
//     Internal state is also cleared: acc, prod, bit count, latched operands.
//   - States: IDLE -> MUL -> ACC -> (IDLE | DONE); DONE -> IDLE.
//   - IDLE: in_ready=1. When in_valid=1, latch a_r=in_a, b_r=in_b, last_r=in_last.
//     Also set prod=0 and cnt=0, then go to MUL. Otherwise stay in IDLE.
//   - MUL: exactly WIDTH cycles. In each cycle, if b_r[cnt]=1,
//     prod <= prod + (a_r << cnt); cnt increments each cycle.
//     prod is 2*WIDTH bits wide and never overflows. At cnt==WIDTH-1, go to ACC.
//   - ACC: one cycle. {carry,acc} <= acc + zero-extended prod.
//     If carry=1, set the sticky ovf flag.
//     If last_r=1: out_data <= new acc, out_ovf <= new ovf, go to DONE.
//     Otherwise go to IDLE.
//   - DONE: out_valid=1. out_data and out_ovf hold stable until out_ready=1.
//     On the handshake, clear acc and ovf, and go to IDLE.
//     The first cycle of the next dot product comes no earlier than the cycle after the handshake.
//   - Timing: a pair accepted at cycle T gives in_ready=1 again at T+WIDTH+2
//     (non-last pair). For a last pair, out_valid=1 at T+WIDTH+2.
//   - in_valid outside IDLE is ignored. The pair is not consumed and the
//     upstream must hold it until in_ready=1.
//   - out_valid and in_ready are never high in the same cycle.
//   - out_data/out_ovf update only on entry to DONE. They keep their last value
//     after the handshake, and out_valid=0 qualifies them.
//   - Reset mid-operation (MUL/ACC/DONE): abandon the partial sum. No result is emitted.
//   - A zero operand still takes the full WIDTH MUL cycles (fixed latency).
// TESTING (WIDTH=4, ACC_WIDTH=12)
//   1 Reset: rst high 2 cycles -> in_ready=1, out_valid=0, out_data=0, out_ovf=0.
//   2 Dot product: send (3,7,last=0) then (5,2,last=1).
//     -> out_data=31, out_ovf=0, out_valid rises 6 cycles after the 2nd accept.
//   3 Single term: (15,15,last=1) -> out_data=225; (0,9,last=1) -> out_data=0
//     with the same 6-cycle latency.
//   4 Backpressure: out_ready=0 for 10 cycles in DONE.
//     -> out_valid and out_data=31 stable, in_ready=0 throughout.
//     Raise out_ready -> next cycle in_ready=1, and the next dot product starts from acc=0.
//   5 Overflow: 19 pairs of (15,15), last on the 19th.
//     -> out_data=(19*225) mod 4096=179, out_ovf=1; next dot product reports out_ovf=0.
//   6 Reset mid-MUL: accept (9,9,last=1), assert rst at accept+2.
//     -> out_valid never rises. A following (2,3,last=1) gives out_data=6.

Source files
------------

// File: rtl/rev_mac_seq.sv
// rev_mac_seq: sequential multiply-accumulate for one dot-product element.
// Each accepted (a,b) pair is multiplied by a shift-add multiplier, one partial
// product per cycle. The product is then added into a wrapping accumulator.
// The pair flagged in_last closes the dot product and publishes the result on a
// valid/ready port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand-pair handshake (ready only while idle)
//   in_a, in_b, in_last      multiplicand, multiplier, final-term flag
//   out_valid/out_ready      result handshake
//   out_data, out_ovf        dot-product result and sticky carry-out flag
module rev_mac_seq #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_last;
    logic [PW-1:0]        r_prod;
    logic [CW-1:0]        r_cnt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_data;
    logic                 r_out_ovf;

    logic                 w_mul_done;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_ovf_nxt;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

    // Last multiply step is the one operating on the top multiplier bit.
    assign w_mul_done = (r_cnt == CW'(WIDTH - 1));

    // Accumulate with an extra bit so the carry out is visible.
    assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH + 1)'(r_prod);
    assign w_ovf_nxt = r_ovf | w_sum[ACC_WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)   w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_done) w_state_nxt = S_ACC;
            S_ACC:   w_state_nxt = r_last ? S_DONE : S_IDLE;
            S_DONE:  if (out_ready)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Operand latch, shift-add multiplier, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_last     <= 1'b0;
            r_prod     <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_last <= in_last;
                        r_prod <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_MUL: begin
                    if (r_b[r_cnt]) begin
                        r_prod <= r_prod + (PW'(r_a) << r_cnt);
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                S_ACC: begin
                    r_acc <= w_sum[ACC_WIDTH-1:0];
                    r_ovf <= w_ovf_nxt;
                    if (r_last) begin
                        r_out_data <= w_sum[ACC_WIDTH-1:0];
                        r_out_ovf  <= w_ovf_nxt;
                    end
                end
                S_DONE: begin
                    // Result consumed: next dot product starts from zero.
                    if (out_ready) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rev_mac_seq.sv
module tb_rev_mac_seq;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned ACC_WIDTH = 12;
    localparam int          LAT       = WIDTH + 2;
    localparam int          MODV      = 1 << ACC_WIDTH;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_ovf;

    rev_mac_seq #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int t_acc    = 0;
    int prev_acc = 0;
    bit chain    = 1'b0;
    int va [64];
    int vb [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Present one pair (called at a negedge) and hold it until accepted.
    task automatic send_pair(input int a, input int b, input bit last);
        int n;
        int t_pres;
        int exp_acc;
        t_pres   = cyc;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        t_acc = cyc;
        if (chain) begin
            exp_acc = (prev_acc + LAT > t_pres) ? prev_acc + LAT : t_pres;
            check("ready_latency", 32'(t_acc), 32'(exp_acc));
        end
        prev_acc = t_acc;
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Wait for the result, check it, optionally backpressure, then consume it.
    task automatic get_result(input int exp_data, input bit exp_ovf, input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check("valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        check("result_latency", 32'(cyc - t_acc), 32'(LAT));
        check("out_data", 32'(out_data), 32'(exp_data));
        check("out_ovf", 32'(out_ovf), 32'(exp_ovf));
        check("ready_in_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(exp_data));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
        check("post_hs_data", 32'(out_data), 32'(exp_data));
    endtask

    // Send va/vb[0..n-1] as one dot product and check it against plain arithmetic.
    task automatic run_dot(input int n, input int gap_max, input int hold);
        int total;
        total = 0;
        chain = 1'b0;
        for (int i = 0; i < n; i++) begin
            total += va[i] * vb[i];
            if (i > 0 && gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_pair(va[i], vb[i], i == n - 1);
            chain = 1'b1;
        end
        chain = 1'b0;
        // Products are non-negative, so a carry happened iff the true sum reached 2^ACC_WIDTH.
        get_result(total % MODV, total >= MODV, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-term dot product: 3*7 + 5*2 = 31.
        va[0] = 3; vb[0] = 7; va[1] = 5; vb[1] = 2;
        run_dot(2, 0, 0);

        // Single terms, including the maximum product and a zero operand.
        va[0] = 15; vb[0] = 15;
        run_dot(1, 0, 0);
        va[0] = 0; vb[0] = 9;
        run_dot(1, 0, 0);

        // Backpressure for 10 cycles, then a fresh dot product starting from zero.
        va[0] = 3; vb[0] = 7; va[1] = 5; vb[1] = 2;
        run_dot(2, 0, 10);
        va[0] = 1; vb[0] = 1;
        run_dot(1, 0, 0);

        // Overflow: 19 * 225 wraps to 179 with ovf set; the next result has ovf clear.
        for (int i = 0; i < 19; i++) begin
            va[i] = 15; vb[i] = 15;
        end
        run_dot(19, 0, 0);
        va[0] = 2; vb[0] = 2;
        run_dot(1, 0, 0);

        // Reset two cycles after accepting a last pair: no result may appear.
        send_pair(9, 9, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("midrst_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        va[0] = 2; vb[0] = 3;
        run_dot(1, 0, 0);

        // Random dot products with idle gaps and random backpressure.
        for (int k = 0; k < 25; k++) begin
            int n;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                va[i] = $urandom_range(0, 15);
                vb[i] = $urandom_range(0, 15);
            end
            run_dot(n, 8, $urandom_range(0, 4));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
